// File: rtl/requant_arbiter_pkg.sv
// Shared definitions for the requantize arbiter: width helpers and FSM encoding.
package requant_arbiter_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   // Tag must be at least one bit wide even for degenerate requester counts.
   function automatic int unsigned tag_width(input int unsigned nreq);
      return (nreq < 2) ? 1 : clog2(nreq);
   endfunction

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StBurst = 1'b1
   } arb_state_e;

endpackage

// File: rtl/requant_fifo.sv
// Synchronous FIFO with occupancy count; same-cycle push and pop supported.
module requant_fifo
   import requant_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      count_q;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW + 1)'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem_q[rd_q];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Upstream credit accounting must keep a push from ever meeting a full FIFO.
   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(push && full && !pop))
      else $error("requant_fifo overflow attempt");

endmodule

// File: rtl/requant_arbiter.sv
// Round-robin burst arbiter feeding a shared fixed-latency requantize stage,
// tracking owner/last through the stage and buffering results in a FIFO.
module requant_arbiter
   import requant_arbiter_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned SIZE       = 8,
   parameter int unsigned RQ_LAT     = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned TW        = tag_width(NREQ)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_last,
   input  logic [32*SIZE*NREQ-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [32*SIZE-1:0]     rq_pixel_in,
   input  logic [8*SIZE-1:0]      rq_pixel_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*SIZE-1:0]      out_data,
   output logic [TW-1:0]          out_tag,
   output logic                   out_last
);

   localparam int unsigned DW = 32 * SIZE;
   localparam int unsigned PW = 8 * SIZE;
   localparam int unsigned FW = PW + TW + 1;
   localparam int unsigned CW = clog2(FIFO_DEPTH) + 1;

   arb_state_e    state_q, state_d;
   logic [TW-1:0] owner_q, owner_d;
   logic [TW-1:0] rr_q, rr_d;
   logic [CW-1:0] inflight_q, inflight_d;

   logic [RQ_LAT-1:0] fl_valid_q;
   logic [RQ_LAT-1:0] fl_last_q;
   logic [TW-1:0]     fl_tag_q [RQ_LAT];

   logic          found;
   logic [TW-1:0] winner;
   logic [TW-1:0] sel;
   logic          accept;
   logic          acc_last;
   logic          credit;
   logic [CW:0]   occupancy;

   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic [FW-1:0] fifo_head;
   logic          fifo_push;
   logic [FW-1:0] fifo_push_data;

   function automatic logic [TW-1:0] next_idx(input logic [TW-1:0] x);
      return (32'(x) == NREQ - 1) ? '0 : x + 1'b1;
   endfunction

   // Conservative: entries leaving the FIFO this cycle are not counted as free.
   assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign credit    = occupancy < (CW + 1)'(FIFO_DEPTH);

   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(rr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = TW'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_d        = rr_q;
      req_ready   = '0;
      sel         = '0;
      accept      = 1'b0;
      acc_last    = 1'b0;
      rq_pixel_in = '0;
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               sel = winner;
               if (found) req_ready[winner] = credit;
            end
            StBurst: begin
               sel = owner_q;
               req_ready[owner_q] = credit;
            end
            default: ;
         endcase
         accept   = |(req_valid & req_ready);
         acc_last = req_last[sel];
         if (accept) begin
            rq_pixel_in = req_data[DW*sel +: DW];
            if (acc_last) begin
               state_d = StIdle;
               rr_d    = next_idx(sel);
            end else begin
               state_d = StBurst;
               owner_d = sel;
            end
         end
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      unique case ({accept, fl_valid_q[RQ_LAT-1]})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         rr_q       <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         inflight_q <= inflight_d;
      end
   end

   // Sideband chain mirrors the requantize stage so tag/last meet their pixels.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fl_valid_q <= '0;
         fl_last_q  <= '0;
         for (int i = 0; i < int'(RQ_LAT); i++) fl_tag_q[i] <= '0;
      end else begin
         fl_valid_q[0] <= accept;
         fl_last_q[0]  <= accept && acc_last;
         fl_tag_q[0]   <= accept ? sel : '0;
         for (int i = 1; i < int'(RQ_LAT); i++) begin
            fl_valid_q[i] <= fl_valid_q[i-1];
            fl_last_q[i]  <= fl_last_q[i-1];
            fl_tag_q[i]   <= fl_tag_q[i-1];
         end
      end
   end

   assign fifo_push      = fl_valid_q[RQ_LAT-1];
   assign fifo_push_data = {rq_pixel_out, fl_tag_q[RQ_LAT-1], fl_last_q[RQ_LAT-1]};

   requant_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (out_valid && out_ready),
      .pop_data  (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_head[FW-1 -: PW];
   assign out_tag   = fifo_head[1 +: TW];
   assign out_last  = fifo_head[0];

endmodule
